// File: rtl/adder_arbiter.sv
// Round-robin front end that shares one registered adder among N_REQ requesters.
// Optional response timeout is compiled in with `define ADDER_ARB_TIMEOUT_EN.
module adder_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_W-1:0]     req_a,
    input  logic [N_REQ*DATA_W-1:0]     req_b,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        add_enable,
    output logic [DATA_W-1:0]           add_a,
    output logic [DATA_W-1:0]           add_b,
    input  logic [DATA_W:0]             add_sum,
    output logic                        rsp_valid,
    output logic [$clog2(N_REQ)-1:0]    rsp_id,
    output logic [DATA_W:0]             rsp_sum,
    input  logic                        rsp_ready,
    output logic                        rsp_drop
);

    localparam int ID_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("adder_arbiter: unsupported N_REQ or TIMEOUT_CYC");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                add_enable_q, add_enable_d;
    logic [DATA_W-1:0]   add_a_q, add_a_d;
    logic [DATA_W-1:0]   add_b_q, add_b_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W:0]     rsp_sum_q, rsp_sum_d;

    logic                found_s;
    logic [ID_W-1:0]     win_s;
    logic [ID_W:0]       idx_s;
    logic [DATA_W-1:0]   sel_a_s;
    logic [DATA_W-1:0]   sel_b_s;
    logic [ID_W-1:0]     ptr_next_s;
    logic [N_REQ-1:0]    req_ready_s;

`ifdef ADDER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
    logic                rsp_drop_q, rsp_drop_d;
`endif

    // Round-robin search starting at rr_ptr, plus operand mux for the winner.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_s = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (idx_s >= (ID_W+1)'(N_REQ)) begin
                idx_s = idx_s - (ID_W+1)'(N_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_valid[idx_s[ID_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[ID_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
        sel_a_s = '0;
        sel_b_s = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (win_s == ID_W'(j)) begin
                sel_a_s = req_a[j*DATA_W +: DATA_W];
                sel_b_s = req_b[j*DATA_W +: DATA_W];
            end else begin
                sel_a_s = sel_a_s;
            end
        end
    end

    // Pointer advances past the requester that just completed.
    always_comb begin
        if (rsp_id_q == ID_W'(N_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = rsp_id_q + ID_W'(1);
        end
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        add_enable_d = 1'b0;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        req_ready_s  = '0;
`ifdef ADDER_ARB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        rsp_drop_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    req_ready_s[win_s] = 1'b1;
                    add_a_d      = sel_a_s;
                    add_b_d      = sel_b_s;
                    rsp_id_d     = win_s;
                    add_enable_d = 1'b1;
                    state_d      = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                rsp_sum_d   = add_sum;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
`ifdef ADDER_ARB_TIMEOUT_EN
                to_cnt_d    = '0;
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rr_ptr_d    = ptr_next_s;
                    state_d     = IDLE;
                end
`ifdef ADDER_ARB_TIMEOUT_EN
                else if (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Consumer stalled too long: abandon the response.
                    rsp_valid_d = 1'b0;
                    rsp_drop_d  = 1'b1;
                    rr_ptr_d    = ptr_next_s;
                    state_d     = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
`else
                else begin
                    state_d = RESP;
                end
`endif
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            add_enable_q <= 1'b0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
`ifdef ADDER_ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
            rsp_drop_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            add_enable_q <= add_enable_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
`ifdef ADDER_ARB_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            rsp_drop_q   <= rsp_drop_d;
`endif
        end
    end

    // The grant is a same-cycle strobe, masked while reset is asserted.
    assign req_ready  = rst ? '0 : req_ready_s;
    assign add_enable = add_enable_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_sum    = rsp_sum_q;
`ifdef ADDER_ARB_TIMEOUT_EN
    assign rsp_drop   = rsp_drop_q;
`else
    assign rsp_drop   = 1'b0;
`endif

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one registered 4-bit adder (enable/a/b in, 5-bit sum out, sum updates on the clk edge where enable=1) among N_REQ requesters.
- Performs round-robin arbitration and accepts one operand pair per transaction.
- Sequences the adder's enable pulse, captures the result and returns it on a single response channel tagged with the requester id.
- Sits between the requester agents and the adder instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 4, operand width; must match the adder; sum width is DATA_W+1.
- TIMEOUT_CYC, 16, response-hold limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_a  input  N_REQ*DATA_W  packed operand a; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  input  N_REQ*DATA_W  packed operand b; same packing.
- req_ready  output  N_REQ  one-hot accept strobe.
- add_enable  output  1  to adder enable.
- add_a  output  DATA_W  to adder a.
- add_b  output  DATA_W  to adder b.
- add_sum  input  DATA_W+1  from adder sum.
- rsp_valid  output  1  response valid.
- rsp_id  output  clog2(N_REQ)  index of the winning requester.
- rsp_sum  output  DATA_W+1  captured sum.
- rsp_ready  input  1  response consumer ready.
- rsp_drop  output  1  timeout drop pulse; driven 0 when the optional feature is compiled out.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, add_enable=0, add_a=0, add_b=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_drop=0.
- rst has priority over every event. Asserting rst mid-transaction discards the in-flight operation, returns to IDLE and resets rr_ptr to 0.
- States:
  - IDLE:
    - Combinational round-robin search of req_valid, starting at rr_ptr and wrapping at N_REQ-1 -> 0.
    - If any request is valid, req_ready[winner]=1 in this same cycle (all other bits 0).
    - On that edge: latch req_a/req_b of the winner into operand registers, latch winner into rsp_id, go to ISSUE.
    - If no request is valid, stay in IDLE with req_ready=0.
  - ISSUE:
    - add_enable=1 for exactly this one cycle; add_a/add_b driven from the operand registers.
    - Go to CAPTURE.
  - CAPTURE:
    - add_sum now holds the result; register it into rsp_sum.
    - add_enable=0. Go to RESP.
  - RESP:
    - rsp_valid=1; rsp_id and rsp_sum held stable.
    - On rsp_valid&&rsp_ready: go to IDLE and set rr_ptr=(rsp_id+1) mod N_REQ.
- add_a/add_b hold their last values outside ISSUE. add_enable is 0 in every state except ISSUE.
- Timing:
  - Minimum request-accept to rsp_valid latency: 3 cycles (accept edge -> ISSUE -> CAPTURE -> RESP).
  - Minimum spacing between successive accepts: 4 cycles when rsp_ready is held high.
- req_ready is never asserted outside IDLE. Requests arriving in other states wait and keep req_valid asserted.
- A requester that drops req_valid before being granted is simply skipped; no state is kept for it.
- Arithmetic: result = a+b, zero-extended, carry in bit DATA_W. Example: 15+15=30 (5'b11110); no truncation.
- Fairness: any continuously-valid requester is granted within N_REQ transactions.

Optional Feature:
- Macro: ADDER_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs while in RESP.
  - If rsp_ready stays low for TIMEOUT_CYC consecutive RESP cycles, rsp_valid is deasserted, rsp_drop=1 for one cycle, state->IDLE, and rr_ptr advances as on a normal completion.
  - The counter clears on entry to RESP and on reset.
- Not defined:
  - No counter; RESP waits indefinitely for rsp_ready.
  - rsp_drop is tied to 0.

Test Plan:
- Reset then single request: req_valid=4'b0001, a=3, b=4, rsp_ready=1 -> req_ready[0] on cycle 0, add_enable high on cycle 1 only, rsp_valid on cycle 3 with rsp_id=0, rsp_sum=7.
- Overflow: requester 2 with a=15, b=15 -> rsp_sum=30, rsp_id=2.
- Round-robin: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; accepts exactly 4 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_sum stable throughout; req_ready stays 0 although req_valid=4'b1111; next grant goes to rsp_id+1 after the handshake.
- Reset mid-operation: assert rst during ISSUE for requester 1 -> next cycle all outputs at reset values; no response is issued; the next grant starts from requester 0.
- With ADDER_ARB_TIMEOUT_EN, TIMEOUT_CYC=16: rsp_ready held 0 -> rsp_drop pulses once on the 16th RESP cycle, rsp_valid falls and IDLE resumes; without the macro, rsp_valid stays high indefinitely.
